sdmac_fifo: RTL and testbench

//  Long-word DMA FIFO between SCSI byte port and 32-bit CPU bus master; directly feeds the CPU bus state machine.

---
 rtl/sdmac_pkg.sv | 35 +++
 rtl/sdmac_fifo_ram.sv | 29 ++
 rtl/sdmac_fifo.sv | 104 ++++++++++
 tb/tb_sdmac_fifo.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdmac_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | sdmac_pkg : shared constants and byte-lane helpers for the SDMAC DMA FIFO
// | Rev 1.0
// +----------------------------------------------------------------------------
package sdmac_pkg;

   localparam int DEPTH_DEF = 8;

   // Byte-enable patterns; lane 0 is the most significant byte (big-endian bus)
   localparam logic [3:0] c_LANE_B0 = 4'b1000;
   localparam logic [3:0] c_LANE_B1 = 4'b0100;
   localparam logic [3:0] c_LANE_B2 = 4'b0010;
   localparam logic [3:0] c_LANE_B3 = 4'b0001;

   function automatic logic [3:0] lane_sel(input logic [1:0] bo);
      case (bo)
         2'd0:    lane_sel = c_LANE_B0;
         2'd1:    lane_sel = c_LANE_B1;
         2'd2:    lane_sel = c_LANE_B2;
         default: lane_sel = c_LANE_B3;
      endcase
   endfunction

   function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] bo);
      case (bo)
         2'd0:    lane_byte = word[31:24];
         2'd1:    lane_byte = word[23:16];
         2'd2:    lane_byte = word[15:8];
         default: lane_byte = word[7:0];
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdmac_fifo_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | sdmac_fifo_ram : DEPTH x 32 storage, per-byte write enables, async read
// | Rev 1.0
// +----------------------------------------------------------------------------
module sdmac_fifo_ram #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          i_clk,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);

   for (genvar k = 0; k < 4; k++) begin : g_lane
      logic [7:0] r_mem [DEPTH];

      always_ff @(posedge i_clk) begin
         if (i_we[k]) r_mem[i_waddr] <= i_wdata[8*k +: 8];
      end

      assign o_rdata[8*k +: 8] = r_mem[i_raddr];
   end

endmodule
`default_nettype wire

// File: rtl/sdmac_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | sdmac_fifo : long-word DMA FIFO between the SCSI byte port and CPU bus master
// | Rev 1.0
// +----------------------------------------------------------------------------
module sdmac_fifo
   import sdmac_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        FIFO_CLR,
   input  logic [31:0] ID,
   input  logic        PLHW,
   input  logic        PLLW,
   input  logic        INCNI,
   input  logic        INCNO,
   input  logic        INCFIFO,
   input  logic        DECFIFO,
   input  logic        DMADIR,
   input  logic        SCSI_WR,
   input  logic [7:0]  SCSI_DIN,
   input  logic        INCBO,
   output logic [31:0] OD,
   output logic [7:0]  SCSI_DOUT,
   output logic        FIFOEMPTY,
   output logic        FIFOFULL,
   output logic        LASTWORD,
   output logic        BOEQ0,
   output logic        BOEQ3
);

   localparam logic [PTR_W:0] c_FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] c_ONE_CNT  = (PTR_W+1)'(1);

   logic [PTR_W-1:0] r_wp;
   logic [PTR_W-1:0] r_rp;
   logic [PTR_W:0]   r_cnt;
   logic [1:0]       r_bo;

   logic             w_flush;
   logic             w_inc;
   logic             w_dec;
   logic [3:0]       w_we;
   logic [31:0]      w_wdata;

   assign w_flush = RESET | FIFO_CLR;
   // Simultaneous INC/DEC cancel; saturate rather than wrap at the ends
   assign w_inc   = INCFIFO & ~DECFIFO & ~FIFOFULL;
   assign w_dec   = DECFIFO & ~INCFIFO & ~FIFOEMPTY;

   always_ff @(posedge CLK) begin
      if (w_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_bo  <= '0;
      end else begin
         if (INCNI) r_wp <= r_wp + 1'b1;
         if (INCNO) r_rp <= r_rp + 1'b1;
         if (INCBO) r_bo <= r_bo + 1'b1;
         if (w_inc)      r_cnt <= r_cnt + 1'b1;
         else if (w_dec) r_cnt <= r_cnt - 1'b1;
      end
   end

   // CPU half-word loads override a SCSI byte landing in the same half
   always_comb begin
      w_wdata = {4{SCSI_DIN}};
      w_we    = (SCSI_WR && !DMADIR) ? lane_sel(r_bo) : 4'b0000;
      if (PLHW) begin
         w_we[3:2]      = 2'b11;
         w_wdata[31:16] = ID[31:16];
      end
      if (PLLW) begin
         w_we[1:0]      = 2'b11;
         w_wdata[15:0]  = ID[15:0];
      end
      if (w_flush) w_we = 4'b0000;
   end

   sdmac_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (PTR_W)
   ) u_ram (
      .i_clk   (CLK),
      .i_we    (w_we),
      .i_waddr (r_wp),
      .i_wdata (w_wdata),
      .i_raddr (r_rp),
      .o_rdata (OD)
   );

   assign SCSI_DOUT = lane_byte(OD, r_bo);
   assign FIFOEMPTY = (r_cnt == '0);
   assign FIFOFULL  = (r_cnt == c_FULL_CNT);
   assign LASTWORD  = (r_cnt == c_ONE_CNT);
   assign BOEQ0     = (r_bo == 2'd0);
   assign BOEQ3     = (r_bo == 2'd3);

endmodule
`default_nettype wire

// File: tb/tb_sdmac_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_sdmac_fifo : vector table, directed corner sequences and random traffic
// | Rev 1.0
// +----------------------------------------------------------------------------
module tb_sdmac_fifo;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0, FIFO_CLR = 1'b0;
   logic [31:0] ID = '0;
   logic        PLHW = 1'b0, PLLW = 1'b0, INCNI = 1'b0, INCNO = 1'b0;
   logic        INCFIFO = 1'b0, DECFIFO = 1'b0, DMADIR = 1'b0;
   logic        SCSI_WR = 1'b0, INCBO = 1'b0;
   logic [7:0]  SCSI_DIN = '0;
   logic [31:0] OD;
   logic [7:0]  SCSI_DOUT;
   logic        FIFOEMPTY, FIFOFULL, LASTWORD, BOEQ0, BOEQ3;

   sdmac_fifo dut (
      .CLK(CLK), .RESET(RESET), .FIFO_CLR(FIFO_CLR), .ID(ID),
      .PLHW(PLHW), .PLLW(PLLW), .INCNI(INCNI), .INCNO(INCNO),
      .INCFIFO(INCFIFO), .DECFIFO(DECFIFO), .DMADIR(DMADIR),
      .SCSI_WR(SCSI_WR), .SCSI_DIN(SCSI_DIN), .INCBO(INCBO),
      .OD(OD), .SCSI_DOUT(SCSI_DOUT), .FIFOEMPTY(FIFOEMPTY),
      .FIFOFULL(FIFOFULL), .LASTWORD(LASTWORD), .BOEQ0(BOEQ0), .BOEQ3(BOEQ3)
   );

   always #5 CLK = ~CLK;

   localparam logic [9:0] S_CLR = 10'h200, S_PLHW = 10'h100, S_PLLW = 10'h080,
                          S_INCNI = 10'h040, S_INCNO = 10'h020, S_INCF = 10'h010,
                          S_DECF = 10'h008, S_DIR = 10'h004, S_SWR = 10'h002,
                          S_INCBO = 10'h001;
   // flag vector layout {EMPTY, FULL, LASTWORD, BOEQ0, BOEQ3}
   localparam logic [4:0] F_E = 5'b10000, F_F = 5'b01000, F_L = 5'b00100,
                          F_B0 = 5'b00010, F_B3 = 5'b00001;

   typedef struct {
      logic [9:0]  stb;
      logic [31:0] id;
      logic [7:0]  din;
      logic [4:0]  flg;
      logic        chk_od;
      logic [31:0] od;
      logic        chk_do;
      logic [7:0]  dout;
   } vec_t;

   vec_t tbl [10];
   int   n_vec = 0;
   int   n_err = 0;

   // reference model state
   int          m_wp, m_rp, m_cnt, m_bo;
   logic [31:0] m_mem [8];
   logic [3:0]  m_vld [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_flags(input string nm, input logic [4:0] exp);
      chk(nm, {27'd0, FIFOEMPTY, FIFOFULL, LASTWORD, BOEQ0, BOEQ3}, {27'd0, exp});
   endtask

   task automatic drive(input logic [9:0] s, input logic [31:0] id, input logic [7:0] din);
      FIFO_CLR = s[9]; PLHW = s[8]; PLLW = s[7]; INCNI = s[6]; INCNO = s[5];
      INCFIFO = s[4]; DECFIFO = s[3]; DMADIR = s[2]; SCSI_WR = s[1]; INCBO = s[0];
      ID = id; SCSI_DIN = din;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      drive(10'd0, 32'd0, 8'd0);
      RESET = 1'b0;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick();
   endtask

   // Apply one cycle of stimulus to the model, working byte by byte from the rules
   task automatic model_step(input logic rst, input logic [9:0] s,
                             input logic [31:0] id, input logic [7:0] din);
      if (rst || s[9]) begin
         m_wp = 0; m_rp = 0; m_cnt = 0; m_bo = 0;
         return;
      end
      for (int b = 0; b < 4; b++) begin
         int pos = 24 - 8*b;
         if ((b < 2 && s[8]) || (b >= 2 && s[7])) begin
            m_mem[m_wp][pos +: 8] = id[pos +: 8];
            m_vld[m_wp][3-b] = 1'b1;
         end else if (s[1] && !s[2] && b == m_bo) begin
            m_mem[m_wp][pos +: 8] = din;
            m_vld[m_wp][3-b] = 1'b1;
         end
      end
      if (s[6]) m_wp = (m_wp + 1) % 8;
      if (s[5]) m_rp = (m_rp + 1) % 8;
      if (s[0]) m_bo = (m_bo + 1) % 4;
      if (s[4] && !s[3] && m_cnt < 8) m_cnt = m_cnt + 1;
      if (s[3] && !s[4] && m_cnt > 0) m_cnt = m_cnt - 1;
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] mask;
      logic [9:0]  s;
      logic        rst;

      // SCSI->memory fill, then read back through the SCSI port and flush
      tbl[0] = '{S_SWR|S_INCBO, 32'h0, 8'h11, F_E,      1'b0, 32'h0,         1'b0, 8'h00};
      tbl[1] = '{S_SWR|S_INCBO, 32'h0, 8'h22, F_E,      1'b0, 32'h0,         1'b0, 8'h00};
      tbl[2] = '{S_SWR|S_INCBO, 32'h0, 8'h33, F_E|F_B3, 1'b0, 32'h0,         1'b0, 8'h00};
      tbl[3] = '{S_SWR|S_INCBO, 32'h0, 8'h44, F_E|F_B0, 1'b1, 32'h11223344,  1'b1, 8'h11};
      tbl[4] = '{S_INCNI|S_INCF, 32'h0, 8'h00, F_L|F_B0, 1'b1, 32'h11223344, 1'b1, 8'h11};
      tbl[5] = '{S_DIR|S_INCBO, 32'h0, 8'h00, F_L,      1'b1, 32'h11223344,  1'b1, 8'h22};
      tbl[6] = '{S_DIR|S_SWR|S_INCBO, 32'h0, 8'hFF, F_L, 1'b1, 32'h11223344, 1'b1, 8'h33};
      tbl[7] = '{S_INCBO,       32'h0, 8'h00, F_L|F_B3, 1'b1, 32'h11223344,  1'b1, 8'h44};
      tbl[8] = '{S_CLR|S_PLHW|S_PLLW|S_INCNI|S_INCF, 32'hDEADBEEF, 8'h00,
                 F_E|F_B0, 1'b1, 32'h11223344, 1'b1, 8'h11};
      tbl[9] = '{S_INCNO|S_DECF, 32'h0, 8'h00, F_E|F_B0, 1'b0, 32'h0,        1'b0, 8'h00};

      do_reset();
      chk_flags("reset_flags", F_E|F_B0);

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].stb, tbl[i].id, tbl[i].din);
         tick();
         chk_flags($sformatf("tbl%0d_flags", i), tbl[i].flg);
         if (tbl[i].chk_od) chk($sformatf("tbl%0d_od", i), OD, tbl[i].od);
         if (tbl[i].chk_do) chk($sformatf("tbl%0d_dout", i), {24'd0, SCSI_DOUT}, {24'd0, tbl[i].dout});
      end

      // Fill to full with wrap of WP, overflow attempt, then drain
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(S_PLHW|S_PLLW|S_INCNI|S_INCF, i, 8'd0);
         tick();
         chk_flags($sformatf("fill%0d_flags", i),
                   (i == 0) ? (F_L|F_B0) : (i == 7) ? (F_F|F_B0) : F_B0);
      end
      drive(S_INCF, 32'd0, 8'd0);
      tick();
      chk_flags("overfill_flags", F_F|F_B0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain%0d_od", i), OD, i);
         drive(S_INCNO|S_DECF, 32'd0, 8'd0);
         tick();
      end
      chk_flags("drained_flags", F_E|F_B0);
      drive(S_PLHW|S_PLLW, 32'hCAFEF00D, 8'd0);
      tick();
      chk("wp_wrapped_od", OD, 32'hCAFEF00D);

      // Simultaneous INC/DEC and DEC at empty
      do_reset();
      repeat (3) begin drive(S_INCF, 32'd0, 8'd0); tick(); end
      drive(S_INCF|S_DECF, 32'd0, 8'd0); tick();
      chk_flags("incdec_cnt3", F_B0);
      drive(S_DECF, 32'd0, 8'd0); tick();
      chk_flags("dec_cnt2", F_B0);
      drive(S_DECF, 32'd0, 8'd0); tick();
      chk_flags("dec_cnt1", F_L|F_B0);
      drive(S_DECF, 32'd0, 8'd0); tick();
      chk_flags("dec_cnt0", F_E|F_B0);
      drive(S_DECF, 32'd0, 8'd0); tick();
      chk_flags("dec_at_empty", F_E|F_B0);
      drive(S_INCF, 32'd0, 8'd0); tick();
      chk_flags("inc_after_sat", F_L|F_B0);

      // Memory->SCSI byte unpacking
      do_reset();
      w = 32'hA1B2C3D4;
      drive(S_PLHW|S_PLLW, w, 8'd0); tick();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("m2s_byte%0d", k), {24'd0, SCSI_DOUT}, {24'd0, w[31-8*k -: 8]});
         drive(S_DIR|S_INCBO, 32'd0, 8'd0); tick();
      end
      chk_flags("m2s_bo_wrap", F_E|F_B0);

      // Clear mid-operation must drop the same-cycle write and pointer moves
      do_reset();
      drive(S_PLHW|S_PLLW, 32'h12345678, 8'd0); tick();
      repeat (8) begin drive(S_INCNI, 32'd0, 8'd0); tick(); end
      repeat (5) begin drive(S_INCF, 32'd0, 8'd0); tick(); end
      repeat (2) begin drive(S_INCBO, 32'd0, 8'd0); tick(); end
      chk_flags("pre_clr_flags", 5'b00000);
      drive(S_CLR|S_PLLW|S_INCNI, 32'h0000BEEF, 8'd0); tick();
      chk_flags("clr_flags", F_E|F_B0);
      chk("clr_no_write", OD, 32'h12345678);
      drive(S_PLHW|S_PLLW, 32'h55AA55AA, 8'd0); tick();
      chk("clr_wp_zero", OD, 32'h55AA55AA);
      drive(S_INCF|S_INCBO, 32'd0, 8'd0); tick();
      RESET = 1'b1;
      drive(S_CLR|S_INCF|S_INCBO, 32'd0, 8'd0); tick();
      chk_flags("reset_and_clr", F_E|F_B0);

      // Random traffic against the reference model
      do_reset();
      m_wp = 0; m_rp = 0; m_cnt = 0; m_bo = 0;
      for (int i = 0; i < 8; i++) begin m_mem[i] = '0; m_vld[i] = '0; end
      for (int n = 0; n < 600; n++) begin
         s = '0;
         s[9] = ($urandom_range(0, 39) == 0);
         for (int b = 0; b < 9; b++) s[b] = ($urandom_range(0, 2) == 0);
         rst = ($urandom_range(0, 99) == 0);
         w = $urandom;
         drive(s, w, 8'($urandom));
         RESET = rst;
         model_step(rst, s, w, SCSI_DIN);
         tick();
         chk_flags($sformatf("rnd%0d_flags", n),
                   {m_cnt == 0, m_cnt == 8, m_cnt == 1, m_bo == 0, m_bo == 3});
         mask = {{8{m_vld[m_rp][3]}}, {8{m_vld[m_rp][2]}}, {8{m_vld[m_rp][1]}}, {8{m_vld[m_rp][0]}}};
         if (mask != '0) chk($sformatf("rnd%0d_od", n), OD & mask, m_mem[m_rp] & mask);
         if (m_vld[m_rp][3-m_bo])
            chk($sformatf("rnd%0d_dout", n), {24'd0, SCSI_DOUT},
                {24'd0, m_mem[m_rp][24-8*m_bo +: 8]});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
